// File: rtl/dmem_arbiter_if.sv
// Master-side request/response bundle for one requester of the data-memory arbiter.
// The master modport belongs to the requester; the slave modport belongs to the arbiter.
interface dmem_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) ();

  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              ack;
  logic [DATA_W-1:0] rdata;
  logic              err;

  modport master (
    output req, we, addr, wdata,
    input  ack, rdata, err
  );

  modport slave (
    input  req, we, addr, wdata,
    output ack, rdata, err
  );

endinterface

// File: rtl/dmem_arbiter.sv
// Two-master round-robin arbiter/sequencer in front of a single-port big-endian data memory.
// Each transaction takes IDLE -> ACCESS -> RESP; illegal addresses never reach the array.
module dmem_arbiter #(
  parameter int unsigned MEM_BYTES = 256,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  dmem_arbiter_if.slave     m0,
  dmem_arbiter_if.slave     m1,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

  localparam logic [ADDR_W-1:0] MaxAddr = ADDR_W'(MEM_BYTES - 4);

  state_e            state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic              grant_q, grant_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              we_q, we_d;
  logic              ack0_q, ack0_d, ack1_q, ack1_d;
  logic              err0_q, err0_d, err1_q, err1_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic              legal;
  logic [DATA_W-1:0] resp_data;

  assign legal = (addr_q[1:0] == 2'b00) && (addr_q <= MaxAddr);

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    we_d         = we_q;
    ack0_d       = 1'b0;
    ack1_d       = 1'b0;
    err0_d       = err0_q;
    err1_d       = err1_q;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
    mem_we       = 1'b0;
    mem_re       = 1'b0;
    resp_data    = '0;

    unique case (state_q)
      StIdle: begin
        if (m0.req || m1.req) begin
          // On a tie the master that did not win last time goes first.
          grant_d      = (m0.req && m1.req) ? ~last_grant_q : m1.req;
          last_grant_d = grant_d;
          addr_d       = grant_d ? m1.addr  : m0.addr;
          wdata_d      = grant_d ? m1.wdata : m0.wdata;
          we_d         = grant_d ? m1.we    : m0.we;
          state_d      = StAccess;
        end
      end
      StAccess: begin
        // Reset gates the strobes so a cancelled access cannot commit at this edge.
        mem_we    = legal && we_q && !reset;
        mem_re    = legal && !we_q && !reset;
        resp_data = (legal && !we_q) ? mem_rdata : '0;
        if (grant_q) begin
          ack1_d   = 1'b1;
          err1_d   = !legal;
          rdata1_d = resp_data;
        end else begin
          ack0_d   = 1'b1;
          err0_d   = !legal;
          rdata0_d = resp_data;
        end
        state_d = StResp;
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b1;
      grant_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      we_q         <= 1'b0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      err0_q       <= 1'b0;
      err1_q       <= 1'b0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      we_q         <= we_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
      err0_q       <= err0_d;
      err1_q       <= err1_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
    end
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  // Reset in the RESP cycle withdraws the pending ack.
  assign m0.ack   = ack0_q && !reset;
  assign m0.err   = err0_q;
  assign m0.rdata = rdata0_q;
  assign m1.ack   = ack1_q && !reset;
  assign m1.err   = err1_q;
  assign m1.rdata = rdata1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a 256-byte big-endian memory model preloaded with
// mem[i] = i, so an untouched word at address a reads {a, a+1, a+2, a+3}.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we, mem_re;

  int checks = 0;
  int fails = 0;
  int both_ack = 0;
  int both_en = 0;
  int mem_writes = 0;

  logic [7:0] mem [0:255];
  logic       loaded = 1'b0;
  logic [7:0] ra, wa;

  dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b0 ();
  dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b1 ();

  dmem_arbiter #(.MEM_BYTES(256), .ADDR_W(32), .DATA_W(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .m0        (b0),
    .m1        (b1),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_re    (mem_re),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  always_comb begin
    mem_rdata = '0;
    ra = mem_addr[7:0];
    if (mem_addr <= 32'd252) mem_rdata = {mem[ra], mem[ra+8'd1], mem[ra+8'd2], mem[ra+8'd3]};
  end

  assign wa = mem_addr[7:0];
  always @(posedge clk) begin
    if (reset && !loaded) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'(i);
      loaded <= 1'b1;
    end else if (mem_we) begin
      mem_writes <= mem_writes + 1;
      if (mem_addr <= 32'd252) begin
        mem[wa]      <= mem_wdata[31:24];
        mem[wa+8'd1] <= mem_wdata[23:16];
        mem[wa+8'd2] <= mem_wdata[15:8];
        mem[wa+8'd3] <= mem_wdata[7:0];
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (b0.ack && b1.ack) both_ack = both_ack + 1;
      if (mem_we && mem_re) both_en = both_en + 1;
    end
  end

  function automatic logic [31:0] word_at(input logic [7:0] a);
    return {mem[a], mem[a+8'd1], mem[a+8'd2], mem[a+8'd3]};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int m, input logic req, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata);
    if (m == 0) begin
      b0.req = req; b0.we = we; b0.addr = addr; b0.wdata = wdata;
    end else begin
      b1.req = req; b1.we = we; b1.addr = addr; b1.wdata = wdata;
    end
  endtask

  // Full transaction from an IDLE cycle; returns in the following IDLE cycle.
  task automatic txn(input string tag, input int m, input logic we, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [31:0] exp_rdata, input logic exp_err);
    logic ack_m, ack_o, err_m;
    logic [31:0] rdata_m;
    drive(m, 1'b1, we, addr, wdata);
    tick;
    check({tag, "/access_we"}, 32'(mem_we), 32'(we && !exp_err));
    check({tag, "/access_re"}, 32'(mem_re), 32'(!we && !exp_err));
    if (!exp_err) check({tag, "/mem_addr"}, mem_addr, addr);
    tick;
    ack_m   = (m == 0) ? b0.ack : b1.ack;
    ack_o   = (m == 0) ? b1.ack : b0.ack;
    err_m   = (m == 0) ? b0.err : b1.err;
    rdata_m = (m == 0) ? b0.rdata : b1.rdata;
    check({tag, "/ack"}, 32'(ack_m), 32'd1);
    check({tag, "/other_ack"}, 32'(ack_o), 32'd0);
    check({tag, "/err"}, 32'(err_m), 32'(exp_err));
    check({tag, "/rdata"}, rdata_m, exp_rdata);
    drive(m, 1'b0, 1'b0, 32'h0, 32'h0);
    tick;
    ack_m = (m == 0) ? b0.ack : b1.ack;
    check({tag, "/ack_drop"}, 32'(ack_m), 32'd0);
  endtask

  int w0;

  initial begin
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0);

    // Reset state
    tick;
    tick;
    check("rst/m0_ack", 32'(b0.ack), 32'd0);
    check("rst/m1_ack", 32'(b1.ack), 32'd0);
    check("rst/mem_we", 32'(mem_we), 32'd0);
    check("rst/mem_re", 32'(mem_re), 32'd0);
    check("rst/mem_addr", mem_addr, 32'h0);
    check("rst/mem_wdata", mem_wdata, 32'h0);
    check("rst/m0_rdata", b0.rdata, 32'h0);
    check("rst/m1_err", 32'(b1.err), 32'd0);
    reset = 1'b0;
    tick;

    // m0 write then read back
    txn("m0_wr10", 0, 1'b1, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
    check("m0_wr10/mem", word_at(8'h10), 32'hDEADBEEF);
    txn("m0_rd10", 0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);

    // Both masters from reset, held for four transactions
    reset = 1'b1;
    tick;
    reset = 1'b0;
    drive(0, 1'b1, 1'b0, 32'h00, 32'h0);
    drive(1, 1'b1, 1'b0, 32'h04, 32'h0);
    for (int k = 1; k <= 12; k++) begin
      tick;
      check($sformatf("rr/m0_ack_c%0d", k), 32'(b0.ack), 32'((k == 2) || (k == 8)));
      check($sformatf("rr/m1_ack_c%0d", k), 32'(b1.ack), 32'((k == 5) || (k == 11)));
      if (k == 11) begin
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
      end
    end
    check("rr/m0_rdata", b0.rdata, 32'h00010203);
    check("rr/m1_rdata", b1.rdata, 32'h04050607);
    check("rr/idle_re", 32'(mem_re), 32'd0);

    // Illegal accesses from m1
    w0 = mem_writes;
    txn("m1_rd0E", 1, 1'b0, 32'h0E, 32'h0, 32'h0, 1'b1);
    txn("m1_rd100", 1, 1'b0, 32'h100, 32'h0, 32'h0, 1'b1);
    txn("m1_wrFD", 1, 1'b1, 32'hFD, 32'hA5A5A5A5, 32'h0, 1'b1);
    txn("m1_wr100", 1, 1'b1, 32'h100, 32'hA5A5A5A5, 32'h0, 1'b1);
    check("illegal/no_writes", 32'(mem_writes - w0), 32'd0);
    check("illegal/mem0C", word_at(8'h0C), 32'h0C0D0E0F);
    check("illegal/memFC", word_at(8'hFC), 32'hFCFDFEFF);

    // Top legal word
    txn("m0_wrFC", 0, 1'b1, 32'hFC, 32'h12345678, 32'h0, 1'b0);
    txn("m0_rdFC", 0, 1'b0, 32'hFC, 32'h0, 32'h12345678, 1'b0);

    // Reset during ACCESS cancels an m1 write
    drive(1, 1'b1, 1'b1, 32'h20, 32'hCAFEF00D);
    tick;
    check("rstacc/we_before", 32'(mem_we), 32'd1);
    reset = 1'b1;
    #1;
    check("rstacc/we_in_reset", 32'(mem_we), 32'd0);
    tick;
    reset = 1'b0;
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("rstacc/no_ack%0d", k), 32'(b1.ack), 32'd0);
      tick;
    end
    check("rstacc/mem20", word_at(8'h20), 32'h20212223);
    txn("m0_rd20", 0, 1'b0, 32'h20, 32'h0, 32'h20212223, 1'b0);

    // Reset during RESP withdraws the ack
    drive(0, 1'b1, 1'b0, 32'h04, 32'h0);
    tick;
    tick;
    reset = 1'b1;
    #1;
    check("rstresp/ack", 32'(b0.ack), 32'd0);
    tick;
    reset = 1'b0;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick;

    // m0 raises req during m1's RESP; served in the following IDLE
    drive(1, 1'b1, 1'b0, 32'h08, 32'h0);
    tick;
    tick;
    check("late/m1_ack", 32'(b1.ack), 32'd1);
    check("late/m1_rdata", b1.rdata, 32'h08090A0B);
    drive(0, 1'b1, 1'b0, 32'h10, 32'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
    tick;
    check("late/idle_re", 32'(mem_re), 32'd0);
    check("late/idle_ack", 32'(b0.ack), 32'd0);
    tick;
    check("late/access_re", 32'(mem_re), 32'd1);
    check("late/access_addr", mem_addr, 32'h10);
    check("late/access_ack", 32'(b0.ack), 32'd0);
    tick;
    check("late/m0_ack", 32'(b0.ack), 32'd1);
    check("late/m0_rdata", b0.rdata, 32'hDEADBEEF);
    check("late/m1_quiet", 32'(b1.ack), 32'd0);
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick;
    tick;

    check("global/both_acks", 32'(both_ack), 32'd0);
    check("global/we_and_re", 32'(both_en), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Two-master round-robin arbiter and sequencer in front of the single-port, byte-addressed, big-endian data memory (32-bit word access, combinational read, posedge write). Master 0 is the CPU load/store stage; master 1 is a secondary requester (debug/DMA loader). The block serialises both masters onto the one memory port with a req/ack handshake. It also blocks illegal accesses before they reach the array.

Parameters:
MEM_BYTES, 256, size of the data memory in bytes; legal word addresses are 0 .. MEM_BYTES-4.
ADDR_W, 32, address width of master and memory ports.
DATA_W, 32, data width; fixed at 32, since the memory packs 4 bytes big-endian.

Ports:
clk  in  1  system clock, all state updates on posedge.
reset  in  1  synchronous, active-high reset.
m0_req  in  1  master 0 request; held high until m0_ack.
m0_we  in  1  master 0 write (1) / read (0).
m0_addr  in  ADDR_W  master 0 byte address.
m0_wdata  in  DATA_W  master 0 write data.
m0_ack  out  1  one-cycle completion pulse to master 0.
m0_rdata  out  DATA_W  read data, valid while m0_ack is high.
m0_err  out  1  access rejected, valid while m0_ack is high.
m1_req, m1_we, m1_addr, m1_wdata, m1_ack, m1_rdata, m1_err  are identical to the m0_* ports, for master 1.
mem_addr  out  ADDR_W  address to the data memory.
mem_wdata  out  DATA_W  write data to the data memory.
mem_we  out  1  memory write enable.
mem_re  out  1  memory read enable.
mem_rdata  in  DATA_W  combinational read data from the data memory.

Behaviour:
Reset
- Reset is synchronous and active-high, sampled on the clk posedge; it overrides every other input.
- Reset values: state=IDLE, last_grant=1 (so m0 wins the first tie), all acks/errs/mem_we/mem_re=0, rdata/mem_addr/mem_wdata=0.

State machine: IDLE -> ACCESS -> RESP -> IDLE.
- IDLE
  - If any req is high, pick the winner and latch its addr, wdata and we, plus the grant index, into internal registers. Go to ACCESS.
  - If no req is high, stay in IDLE.
- Arbitration
  - If only one req is high, that master wins.
  - If both are high, the master that is not last_grant wins.
  - last_grant updates on entry to ACCESS.
- ACCESS (exactly 1 cycle)
  - mem_addr and mem_wdata are driven from the latched registers.
  - Legal write: mem_we=1 for this single cycle.
  - Legal read: mem_re=1, and mem_rdata is captured into the response register at the end of the cycle.
  - Illegal access (addr[1:0]!=0 or addr>MEM_BYTES-4): mem_we=mem_re=0, the error flag is set, and the response data is 0.
  - Always go to RESP.
- RESP (1 cycle)
  - The granted master sees ack=1, plus rdata (zero for writes) and err.
  - The other master's ack stays 0 throughout.
  - Return to IDLE.
- All master-side outputs are registered. rdata/err values are meaningful only while ack is high; they hold their last value otherwise.

Timing
- Latency: req sampled high at edge N, memory access in cycle N+1, ack high in cycle N+2. Throughput is one transaction per 3 cycles.
- Handshake: the master holds req, addr, wdata and we stable until it sees ack. The arbiter ignores changes to these after latching. A req still high in the IDLE cycle after ack counts as a new request.
- Fairness: if both masters hold req continuously, grants alternate m0, m1, m0, ... No master waits more than one foreign transaction.

Boundary conditions
- Requests are never accepted in ACCESS or RESP. A master that raises req in those states is served in the next IDLE, and its req must stay high.
- addr = MEM_BYTES-4 is legal. Both MEM_BYTES-3 and MEM_BYTES (out of range) give err=1, and no memory write occurs.
- Reset asserted during ACCESS cancels the access: mem_we is 0 in the reset cycle, no ack is issued, and the next state is IDLE.
- Reset asserted during RESP suppresses the ack.
- mem_we and mem_re are never high together; both are 0 outside ACCESS.

Test Plan:
- m0 writes 0xDEADBEEF to addr 0x10, then reads 0x10 -> mem_we pulses 1 cycle in the write's ACCESS; the read's m0_ack cycle shows m0_rdata=0xDEADBEEF and m0_err=0; each ack arrives 2 cycles after the req is sampled.
- m0 and m1 both raise req in the same cycle out of reset, both held for 4 transactions -> grant order m0, m1, m0, m1; acks spaced 3 cycles apart; never both acks high.
- m1 reads addr 0x0E (misaligned) and then addr 0x100 with MEM_BYTES=256 -> m1_err=1 and m1_rdata=0 on both; mem_we and mem_re stay 0 throughout; memory contents are unchanged.
- m0 writes 0x12345678 to addr 0xFC (top word) -> err=0; a subsequent read of 0xFC returns 0x12345678.
- m1 write to 0x20 is in ACCESS when reset is pulsed for 1 cycle -> no ack, state IDLE, mem_we=0 on the reset edge; a read of 0x20 returns its pre-test value.
- m0 raises req during m1's RESP cycle -> m0 is latched at the following IDLE edge, and m0_ack arrives exactly 2 cycles after that edge.
